// File: rtl/scale_selector.sv
// Debounced up/down buttons step a saturating divide-scale; each change holds the divider in reload.
// Latency: held button -> scale update at DEBOUNCE+2 edges; no backpressure (events during reload are dropped).
module scale_selector #(
    parameter int WIDTH      = 8,
    parameter int DEBOUNCE   = 16,
    parameter int RELOAD_LEN = 2,
    parameter int INIT_SCALE = 1
) (
    input  logic             clk_in,
    input  logic             nrst,
    input  logic             btn_up,
    input  logic             btn_down,
    output logic [WIDTH-1:0] scale,
    output logic             div_nrst,
    output logic             changed,
    output logic             busy
);
    localparam int CW = $clog2(DEBOUNCE) + 1;
    localparam int RW = $clog2(RELOAD_LEN) + 1;

    typedef enum logic {IDLE, RELOAD} state_t;

    // bit 0 = up, bit 1 = down
    logic [1:0]         btn_raw;
    logic [1:0]         sync1, sync2, deb, evt;
    logic [1:0][CW-1:0] cnt;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   scale_nxt;
    logic               div_nrst_nxt, changed_nxt;
    logic [RW-1:0]      rcnt, rcnt_nxt;

    assign btn_raw = {btn_down, btn_up};

    always_ff @(posedge clk_in) begin
        if (!nrst) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            evt   <= '0;
            cnt   <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                evt[i] <= 1'b0;
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CW'(DEBOUNCE - 1)) begin
                    // Accept the new level; only a rising level is a press
                    deb[i] <= ~deb[i];
                    cnt[i] <= '0;
                    evt[i] <= ~deb[i];
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        scale_nxt    = scale;
        div_nrst_nxt = 1'b1;
        changed_nxt  = 1'b0;
        rcnt_nxt     = rcnt;
        case (state)
            IDLE: begin
                rcnt_nxt = '0;
                if (evt[0] && !evt[1] && scale != '1) begin
                    scale_nxt    = scale + 1'b1;
                    changed_nxt  = 1'b1;
                    div_nrst_nxt = 1'b0;
                    state_nxt    = RELOAD;
                end else if (evt[1] && !evt[0] && scale != '0) begin
                    scale_nxt    = scale - 1'b1;
                    changed_nxt  = 1'b1;
                    div_nrst_nxt = 1'b0;
                    state_nxt    = RELOAD;
                end
            end
            RELOAD: begin
                div_nrst_nxt = 1'b0;
                if (rcnt == RW'(RELOAD_LEN - 1)) begin
                    div_nrst_nxt = 1'b1;
                    state_nxt    = IDLE;
                    rcnt_nxt     = '0;
                end else begin
                    rcnt_nxt = rcnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!nrst) begin
            state    <= IDLE;
            scale    <= WIDTH'(INIT_SCALE);
            div_nrst <= 1'b0;
            changed  <= 1'b0;
            rcnt     <= '0;
        end else begin
            state    <= state_nxt;
            scale    <= scale_nxt;
            div_nrst <= div_nrst_nxt;
            changed  <= changed_nxt;
            rcnt     <= rcnt_nxt;
        end
    end

    assign busy = (state == RELOAD);

endmodule

// File: doc/scale_selector.md
SCALE_SELECTOR -- requirements
Module: scale_selector

Interface
REQ-001 SHALL have parameter: WIDTH, 8, width of scale value.
REQ-002 SHALL have parameter: DEBOUNCE, 16, consecutive stable cycles required to accept a button level change (>=1).
REQ-003 SHALL have parameter: RELOAD_LEN, 2, cycles div_nrst is held low after a scale change (>=1).
REQ-004 SHALL have parameter: INIT_SCALE, 1, scale value loaded at reset.
REQ-005 SHALL have port: clk_in  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port: nrst  input  1  reset; synchronous, active-low.
REQ-007 SHALL have port: btn_up  input  1  raw asynchronous increment button, active-high.
REQ-008 SHALL have port: btn_down  input  1  raw asynchronous decrement button, active-high.
REQ-009 SHALL have port: scale  output  WIDTH  registered divide-scale value for the downstream clock divider.
REQ-010 SHALL have port: div_nrst  output  1  registered active-low reload strobe for the downstream divider's nrst.
REQ-011 SHALL have port: changed  output  1  registered one-cycle pulse marking a scale update.
REQ-012 SHALL have port: busy  output  1  high while in RELOAD state.

Function
REQ-013 Each button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-014 Per button, a debounce counter SHALL increment each cycle the synchronized level differs from the debounced level and clear when they match.
REQ-015 The debounced level SHALL flip on the edge where the counter would reach DEBOUNCE; the counter SHALL clear on that edge.
REQ-016 A press event SHALL be a 0->1 transition of a debounced level; 1->0 transitions SHALL produce no event.
REQ-017 With btn_up first sampled high at edge k and held, scale SHALL update at edge k+DEBOUNCE+2.
REQ-018 FSM states SHALL be IDLE and RELOAD.
REQ-019 In IDLE, an up event SHALL set scale to scale+1 unless scale equals 2^WIDTH-1 (saturate, no change).
REQ-020 In IDLE, a down event SHALL set scale to scale-1 unless scale equals 0 (saturate, no change).
REQ-021 Up and down events on the same cycle SHALL be ignored (no change, no reload).
REQ-022 On an edge that changes scale: changed SHALL be 1 for exactly that cycle, div_nrst SHALL go 0, FSM SHALL enter RELOAD.
REQ-023 A saturated (no-change) event SHALL NOT pulse changed, drive div_nrst low, or leave IDLE.
REQ-024 In RELOAD, div_nrst SHALL stay 0 for exactly RELOAD_LEN cycles, then return to 1 with FSM back in IDLE on the same edge.
REQ-025 scale SHALL be stable throughout RELOAD so the downstream divider captures the new value while div_nrst is low.
REQ-026 Events arriving in RELOAD SHALL be dropped, not queued.
REQ-027 busy SHALL equal (state == RELOAD).
REQ-028 Scale value 0 SHALL be legal (downstream bypass); no lower clamp other than REQ-020.

Reset
REQ-029 While nrst is 0 at a rising edge: scale=INIT_SCALE, div_nrst=0, changed=0, busy=0, FSM=IDLE, synchronizers, debounced levels and counters = 0.
REQ-030 On the first edge with nrst=1, div_nrst SHALL become 1 (downstream leaves reset holding INIT_SCALE).
REQ-031 Reset asserted mid-RELOAD or mid-debounce SHALL abort it with no pending event after release.
REQ-032 A button already held when nrst releases SHALL produce one event after full debounce (REQ-017 timing from first post-reset edge).

Verification (DEBOUNCE=4, RELOAD_LEN=2, WIDTH=8, INIT_SCALE=1)
REQ-033 Reset, then btn_up high from edge k -> scale 1->2 at edge k+6, changed=1 one cycle, div_nrst=0 for exactly 2 cycles, busy matches.
REQ-034 btn_up glitch high 3 cycles, low, repeated -> scale never changes, div_nrst stays 1.
REQ-035 scale=0, btn_down press -> no change, no changed pulse, div_nrst stays 1; scale=255, btn_up press -> same.
REQ-036 btn_up and btn_down rise on same edge and held -> no change; second btn_down press debounced during RELOAD from prior up -> dropped.
REQ-037 nrst pulled low during RELOAD -> next edge scale=1, div_nrst=0, busy=0; after release div_nrst=1 on first edge, no residual event.
REQ-038 Ten separate btn_up presses from reset -> scale=11, ten changed pulses, ten 2-cycle div_nrst low windows.
